// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if
//   Signals between the interrupt controller, the CPU it feeds and the
//   external request lines. The clock and reset are not part of the bundle.
//
//   irq_in       raw external request lines, asynchronous to clk
//   bus_we       CPU write strobe
//   Direcciones  CPU address bus
//   Datos        CPU data bus (bits [7:0] carry the mask on a mask write)
//   intr_ack     CPU acknowledge, one-cycle pulse
//   intr         one-hot request to the CPU, or all zeros
//   pending      pending-request register, for observation
//   mask         current mask register
//
//   master: the environment side (CPU, request sources)
//   slave : the interrupt controller
interface intr_ctrl_if;
  logic [7:0]  irq_in;
  logic        bus_we;
  logic [15:0] Direcciones;
  logic [15:0] Datos;
  logic        intr_ack;
  logic [7:0]  intr;
  logic [7:0]  pending;
  logic [7:0]  mask;

  modport master (
    output irq_in,
    output bus_we,
    output Direcciones,
    output Datos,
    output intr_ack,
    input  intr,
    input  pending,
    input  mask
  );

  modport slave (
    input  irq_in,
    input  bus_we,
    input  Direcciones,
    input  Datos,
    input  intr_ack,
    output intr,
    output pending,
    output mask
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl
//   Interrupt controller sitting in front of the CPU intr[7:0] input.
//   - Synchronises eight asynchronous request lines (two flops each) and
//     turns their rising edges into pending bits.
//   - Snoops CPU bus writes to MASK_ADDR to update an 8-bit enable mask.
//   - Presents the highest enabled pending request (bit 7 highest) as a
//     held one-hot vector, retires it on intr_ack, or re-pends it after
//     HOLD_CYCLES cycles without an ack.
//   - A GAP cycle after every request guarantees intr returns to zero
//     between two consecutive requests.
//
//   Ports
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears all state immediately
//     bus    intr_ctrl_if.slave: irq_in, bus_we, Direcciones, Datos,
//            intr_ack in; intr, pending, mask out (all registered)
//
//   Parameters
//     MASK_ADDR    bus address of the mask register
//     MASK_RST     mask value after reset (1 = enabled)
//     HOLD_CYCLES  cycles intr is held waiting for an ack, 1..255
module intr_ctrl #(
  parameter logic [15:0] MASK_ADDR   = 16'hFF00,
  parameter logic [7:0]  MASK_RST    = 8'hFF,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  // Timer reload value: the timer counts HOLD_CYCLES-1 down to 0, so the
  // request is visible for exactly HOLD_CYCLES cycles before it times out.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // One-hot of the highest set bit; zero when the vector is zero.
  function automatic logic [7:0] top_one_hot(input logic [7:0] vec);
    logic [7:0] result;
    result = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) begin
        result    = 8'h00;
        result[i] = 1'b1;
      end
    end
    return result;
  endfunction

  logic [7:0] s1_r;
  logic [7:0] s2_r;
  logic [7:0] edge_s;
  logic [7:0] mask_r;
  logic       mask_we_s;
  logic [7:0] pending_r;
  logic [7:0] pending_next_s;
  logic [7:0] cand_s;
  logic [7:0] dispatch_s;
  logic [7:0] clr_s;
  logic [7:0] repend_s;
  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] intr_r;
  logic [7:0] intr_next_s;
  logic [7:0] timer_r;
  logic [7:0] timer_next_s;
  logic       unused_datos_s;

  // Upper data bits never carry mask information.
  assign unused_datos_s = ^bus.Datos[15:8];

  // s1 is the first sampled copy; a line that stays high yields one edge.
  assign edge_s = s1_r & ~s2_r;

  assign mask_we_s = bus.bus_we && (bus.Direcciones == MASK_ADDR);

  // Edges are latched regardless of mask; only dispatch is gated.
  assign cand_s     = pending_r & mask_r;
  assign dispatch_s = top_one_hot(cand_s);

  // Clear happens first so a same-cycle set (edge or re-pend) wins.
  assign pending_next_s = (pending_r & ~clr_s) | edge_s | repend_s;

  // Two-flop synchroniser on the raw request lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r <= 8'h00;
      s2_r <= 8'h00;
    end else begin
      s1_r <= bus.irq_in;
      s2_r <= s1_r;
    end
  end

  // Mask register, captured from snooped CPU writes to MASK_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r <= MASK_RST;
    end else if (mask_we_s) begin
      mask_r <= bus.Datos[7:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Pending register, updated every cycle in every FSM state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 8'h00;
    end else begin
      pending_r <= pending_next_s;
    end
  end

  // Dispatch FSM state, held request vector and hold timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      intr_r  <= 8'h00;
      timer_r <= 8'h00;
    end else begin
      state_r <= state_next_s;
      intr_r  <= intr_next_s;
      timer_r <= timer_next_s;
    end
  end

  // Dispatch FSM next-state and request/clear/re-pend decisions.
  always_comb begin
    state_next_s = state_r;
    intr_next_s  = intr_r;
    timer_next_s = timer_r;
    clr_s        = 8'h00;
    repend_s     = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (cand_s != 8'h00) begin
          intr_next_s  = dispatch_s;
          clr_s        = dispatch_s;
          timer_next_s = HOLD_LOAD;
          state_next_s = ST_BUSY;
        end else begin
          intr_next_s  = 8'h00;
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Ack is checked first so it beats a timeout in the same cycle.
        if (bus.intr_ack) begin
          intr_next_s  = 8'h00;
          state_next_s = ST_GAP;
        end else if (timer_r == 8'h00) begin
          // The presented bit goes back to pending even if now masked.
          repend_s     = intr_r;
          intr_next_s  = 8'h00;
          state_next_s = ST_GAP;
        end else begin
          timer_next_s = timer_r - 8'd1;
        end
      end
      ST_GAP: begin
        intr_next_s  = 8'h00;
        state_next_s = ST_IDLE;
      end
      default: begin
        intr_next_s  = 8'h00;
        timer_next_s = 8'h00;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign bus.intr    = intr_r;
  assign bus.pending = pending_r;
  assign bus.mask    = mask_r;

endmodule
